// File: rtl/stage_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : stage_wb_pipe
//  Purpose  : Registered RISC-V write-back stage. Selects the result source
//             (load / ALU / PC+4 / CSR), formats load data by size, sign and
//             byte lane, and drives a one-cycle register-file write port with
//             stall/flush control and x0 write suppression.
//  Options  : WB_INSTRET_EN - adds the retired-instruction counter and the
//             instret output port.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module stage_wb_pipe #(
    parameter int REG_WIDTH = `REG_WIDTH,
    parameter int RF_ADDR_W = 5
`ifdef WB_INSTRET_EN
    ,
    parameter int INSTRET_W = 64
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mem_wb_valid,
    input  logic                 mem_wb_rd_we,
    input  logic [RF_ADDR_W-1:0] mem_wb_rd,
    input  logic [1:0]           mem_wb_wb_sel,
    input  logic [2:0]           mem_wb_funct3,
    input  logic [2:0]           mem_wb_addr_lo,
    input  logic [REG_WIDTH-1:0] mem_wb_alu_out,
    input  logic [REG_WIDTH-1:0] mem_wb_data_out,
    input  logic [REG_WIDTH-1:0] mem_wb_pc_plus4,
    input  logic [REG_WIDTH-1:0] mem_wb_csr_rdata,
    input  logic                 wb_stall,
    input  logic                 wb_flush,
    output logic                 wb_valid,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [REG_WIDTH-1:0] rf_wdata
`ifdef WB_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0] instret
`endif
);

    // Byte-lane offset is limited to the lanes that exist in one data word.
    localparam logic [2:0] c_OFF_MASK = (REG_WIDTH == 64) ? 3'b111 : 3'b011;
    localparam bit         c_IS_RV64  = (REG_WIDTH == 64);

    localparam logic [1:0] c_SEL_LOAD = 2'b00;
    localparam logic [1:0] c_SEL_ALU  = 2'b01;
    localparam logic [1:0] c_SEL_PC4  = 2'b10;
    localparam logic [1:0] c_SEL_CSR  = 2'b11;

    logic [2:0]           w_byte_off;
    logic [2:0]           w_half_off;
    logic [2:0]           w_word_off;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_word;
    logic [REG_WIDTH-1:0] w_load_data;
    logic [REG_WIDTH-1:0] w_wb_data;
    logic                 w_rf_we_nxt;

    logic                 r_wb_valid;
    logic                 r_rf_we;
    logic [RF_ADDR_W-1:0] r_rf_waddr;
    logic [REG_WIDTH-1:0] r_rf_wdata;

    // Lane offsets: halves ignore bit 0, words only use bit 2 (RV64 only).
    assign w_byte_off = mem_wb_addr_lo & c_OFF_MASK;
    assign w_half_off = w_byte_off & 3'b110;
    assign w_word_off = c_IS_RV64 ? (w_byte_off & 3'b100) : 3'b000;

    // Extract the addressed byte, half and word from the raw read word.
    assign w_byte = 8'(mem_wb_data_out >> {w_byte_off, 3'b000});
    assign w_half = 16'(mem_wb_data_out >> {w_half_off, 3'b000});
    assign w_word = 32'(mem_wb_data_out >> {w_word_off, 3'b000});

    // Load formatting by funct3; unsupported codes pass the raw word through.
    always_comb begin
        w_load_data = mem_wb_data_out;
        case (mem_wb_funct3)
            3'b000:  w_load_data = REG_WIDTH'($signed(w_byte));
            3'b100:  w_load_data = REG_WIDTH'(w_byte);
            3'b001:  w_load_data = REG_WIDTH'($signed(w_half));
            3'b101:  w_load_data = REG_WIDTH'(w_half);
            3'b010:  w_load_data = REG_WIDTH'($signed(w_word));
            3'b110: begin
                if (c_IS_RV64) begin
                    w_load_data = REG_WIDTH'(w_word);
                end
            end
            default: w_load_data = mem_wb_data_out;
        endcase
    end

    // Result source select; 00/01 keep the old 1-bit memory/ALU meaning.
    always_comb begin
        w_wb_data = w_load_data;
        case (mem_wb_wb_sel)
            c_SEL_LOAD: w_wb_data = w_load_data;
            c_SEL_ALU:  w_wb_data = mem_wb_alu_out;
            c_SEL_PC4:  w_wb_data = mem_wb_pc_plus4;
            c_SEL_CSR:  w_wb_data = mem_wb_csr_rdata;
            default:    w_wb_data = w_load_data;
        endcase
    end

    // x0 is hard-wired to zero, so never request a write to it.
    assign w_rf_we_nxt = mem_wb_valid & mem_wb_rd_we & (mem_wb_rd != '0);

    // Output register: flush kills the slot but keeps address/data,
    // stall holds everything (a repeated write of the same value is harmless).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_valid <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (wb_flush) begin
            r_wb_valid <= 1'b0;
            r_rf_we    <= 1'b0;
        end else if (!wb_stall) begin
            r_wb_valid <= mem_wb_valid;
            r_rf_we    <= w_rf_we_nxt;
            r_rf_waddr <= mem_wb_rd;
            r_rf_wdata <= w_wb_data;
        end
    end

    assign wb_valid = r_wb_valid;
    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

`ifdef WB_INSTRET_EN
    logic [INSTRET_W-1:0] r_instret;

    // Count every valid slot that actually enters the stage; wraps silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instret <= '0;
        end else if (!wb_flush && !wb_stall && mem_wb_valid) begin
            r_instret <= r_instret + INSTRET_W'(1);
        end
    end

    assign instret = r_instret;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stage_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_wb_pipe
//  Purpose  : Scoreboard testbench for stage_wb_pipe (32-bit datapath).
//             Directed vectors push hand-computed expectations; a monitor
//             pops and compares them on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stage_wb_pipe;

    localparam int REG_WIDTH = 32;
    localparam int RF_ADDR_W = 5;
`ifdef WB_INSTRET_EN
    localparam int INSTRET_W = 4;
`endif

    logic        clk;
    logic        reset_n;
    logic        mem_wb_valid;
    logic        mem_wb_rd_we;
    logic [4:0]  mem_wb_rd;
    logic [1:0]  mem_wb_wb_sel;
    logic [2:0]  mem_wb_funct3;
    logic [2:0]  mem_wb_addr_lo;
    logic [31:0] mem_wb_alu_out;
    logic [31:0] mem_wb_data_out;
    logic [31:0] mem_wb_pc_plus4;
    logic [31:0] mem_wb_csr_rdata;
    logic        wb_stall;
    logic        wb_flush;
    logic        wb_valid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_INSTRET_EN
    logic [3:0]  instret;
`endif

    stage_wb_pipe #(
        .REG_WIDTH (REG_WIDTH),
        .RF_ADDR_W (RF_ADDR_W)
`ifdef WB_INSTRET_EN
        ,
        .INSTRET_W (INSTRET_W)
`endif
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mem_wb_valid     (mem_wb_valid),
        .mem_wb_rd_we     (mem_wb_rd_we),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_wb_sel    (mem_wb_wb_sel),
        .mem_wb_funct3    (mem_wb_funct3),
        .mem_wb_addr_lo   (mem_wb_addr_lo),
        .mem_wb_alu_out   (mem_wb_alu_out),
        .mem_wb_data_out  (mem_wb_data_out),
        .mem_wb_pc_plus4  (mem_wb_pc_plus4),
        .mem_wb_csr_rdata (mem_wb_csr_rdata),
        .wb_stall         (wb_stall),
        .wb_flush         (wb_flush),
        .wb_valid         (wb_valid),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata)
`ifdef WB_INSTRET_EN
        ,
        .instret          (instret)
`endif
    );

    typedef struct {
        string       name;
        int          due;
        logic        v;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  ir;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 0;

    // Expected output registers, updated when a vector is issued.
    logic        m_v  = 1'b0;
    logic        m_we = 1'b0;
    logic [4:0]  m_a  = '0;
    logic [31:0] m_d  = '0;
    logic [3:0]  m_ir = '0;

    localparam logic [31:0] c_LD_WORD = 32'h80F0_7F81;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (mon_en && sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({wb_valid, rf_we, rf_waddr, rf_wdata} !== {e.v, e.we, e.a, e.d}) begin
                    n_err++;
                    $display("FAIL %s: got v=%0b we=%0b a=%0d d=%h, required v=%0b we=%0b a=%0d d=%h",
                             e.name, wb_valid, rf_we, rf_waddr, rf_wdata, e.v, e.we, e.a, e.d);
                end
`ifdef WB_INSTRET_EN
                n_cmp++;
                if (instret !== e.ir) begin
                    n_err++;
                    $display("FAIL %s instret: got %0d, required %0d", e.name, instret, e.ir);
                end
`endif
            end
        end
    end

    task automatic step(input string name, input logic v, input logic we,
                        input logic [4:0] rd, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [2:0] alo,
                        input logic [31:0] alu, input logic [31:0] dout,
                        input logic [31:0] pc4, input logic [31:0] csr,
                        input logic st, input logic fl, input logic [31:0] exp_d);
        exp_t e;
        @(posedge clk);
        #1;
        mem_wb_valid     = v;
        mem_wb_rd_we     = we;
        mem_wb_rd        = rd;
        mem_wb_wb_sel    = sel;
        mem_wb_funct3    = f3;
        mem_wb_addr_lo   = alo;
        mem_wb_alu_out   = alu;
        mem_wb_data_out  = dout;
        mem_wb_pc_plus4  = pc4;
        mem_wb_csr_rdata = csr;
        wb_stall         = st;
        wb_flush         = fl;
        if (fl) begin
            m_v  = 1'b0;
            m_we = 1'b0;
        end else if (!st) begin
            m_v  = v;
            m_we = v & we & (rd != 5'd0);
            m_a  = rd;
            m_d  = exp_d;
        end
        if (!fl && !st && v) m_ir = m_ir + 4'd1;
        e.name = name; e.due = cyc + 1;
        e.v = m_v; e.we = m_we; e.a = m_a; e.d = m_d; e.ir = m_ir;
        sb_q.push_back(e);
    endtask

    task automatic alu(input string name, input logic [4:0] rd, input logic [31:0] val,
                       input logic st, input logic fl);
        step(name, 1'b1, 1'b1, rd, 2'b01, 3'b000, 3'b000, val, 32'h0, 32'h0, 32'h0, st, fl, val);
    endtask

    task automatic ld(input string name, input logic [2:0] f3, input logic [2:0] alo,
                      input logic [31:0] exp_d);
        step(name, 1'b1, 1'b1, 5'd10, 2'b00, f3, alo, 32'h0, c_LD_WORD, 32'h0, 32'h0, 1'b0, 1'b0, exp_d);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending, required 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({wb_valid, rf_we, rf_waddr, rf_wdata} !== 39'd0) begin
            n_err++;
            $display("FAIL %s: got v=%0b we=%0b a=%0d d=%h, required all zero",
                     name, wb_valid, rf_we, rf_waddr, rf_wdata);
        end
`ifdef WB_INSTRET_EN
        n_cmp++;
        if (instret !== 4'd0) begin
            n_err++;
            $display("FAIL %s instret: got %0d, required 0", name, instret);
        end
`endif
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, required completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        mem_wb_valid = 0; mem_wb_rd_we = 0; mem_wb_rd = 0; mem_wb_wb_sel = 0;
        mem_wb_funct3 = 0; mem_wb_addr_lo = 0; mem_wb_alu_out = 0; mem_wb_data_out = 0;
        mem_wb_pc_plus4 = 0; mem_wb_csr_rdata = 0; wb_stall = 0; wb_flush = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2 check_zero("reset_state");
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        mon_en = 1'b1;

        // Source select and load formatting
        alu("alu_rd5", 5'd5, 32'h1234_5678, 1'b0, 1'b0);
        ld("lb_off0",   3'b000, 3'd0, 32'hFFFF_FF81);
        ld("lb_off1",   3'b000, 3'd1, 32'h0000_007F);
        ld("lbu_off3",  3'b100, 3'd3, 32'h0000_0080);
        ld("lb_off7",   3'b000, 3'd7, 32'hFFFF_FF80);
        ld("lh_off2",   3'b001, 3'd2, 32'hFFFF_80F0);
        ld("lh_off3",   3'b001, 3'd3, 32'hFFFF_80F0);
        ld("lhu_off0",  3'b101, 3'd0, 32'h0000_7F81);
        ld("lw",        3'b010, 3'd0, 32'h80F0_7F81);
        ld("lwu_rv32",  3'b110, 3'd2, 32'h80F0_7F81);
        ld("ld_rv32",   3'b011, 3'd1, 32'h80F0_7F81);
        ld("f3_111",    3'b111, 3'd3, 32'h80F0_7F81);
        step("x0_pc4", 1'b1, 1'b1, 5'd0, 2'b10, 3'b000, 3'd0, 32'hFFFF_FFFF, 32'h0,
             32'h0000_0104, 32'h0, 1'b0, 1'b0, 32'h0000_0104);
        step("csr_rd9", 1'b1, 1'b1, 5'd9, 2'b11, 3'b000, 3'd0, 32'h1, 32'h2,
             32'h3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF);
        step("invalid_slot", 1'b0, 1'b1, 5'd3, 2'b01, 3'b000, 3'd0, 32'h55, 32'h0,
             32'h0, 32'h0, 1'b0, 1'b0, 32'h55);
        step("no_rd_we", 1'b1, 1'b0, 5'd4, 2'b01, 3'b000, 3'd0, 32'h66, 32'h0,
             32'h0, 32'h0, 1'b0, 1'b0, 32'h66);

        // Stall holds, flush beats stall, flush alone kills the slot
        alu("load_A",      5'd7,  32'hAAAA_0007, 1'b0, 1'b0);
        alu("stall1",      5'd8,  32'h1111_1111, 1'b1, 1'b0);
        alu("stall2",      5'd0,  32'h2222_2222, 1'b1, 1'b0);
        alu("stall3",      5'd11, 32'h3333_3333, 1'b1, 1'b0);
        alu("flush_stall", 5'd12, 32'h0000_0022, 1'b1, 1'b1);
        alu("flush_only",  5'd13, 32'h0000_0033, 1'b0, 1'b1);
        alu("after_flush", 5'd14, 32'h0000_0044, 1'b0, 1'b0);
        alu("stall_hold",  5'd15, 32'h0000_0099, 1'b1, 1'b0);
        drain();

        // Asynchronous reset while stalled with live outputs
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_zero("async_reset");
        m_v = 0; m_we = 0; m_a = 0; m_d = 0; m_ir = 0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // Retire counting: flushed/stalled slots do not count, 17 valid wrap to 1
        alu("cnt_flush", 5'd1, 32'h0000_00F0, 1'b0, 1'b1);
        alu("cnt_stall", 5'd2, 32'h0000_00F1, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) begin
            alu("cnt_slot", 5'(i + 1), 32'(i + 100), 1'b0, 1'b0);
        end
        step("idle", 1'b0, 1'b0, 5'd0, 2'b01, 3'b000, 3'd0, 32'h0, 32'h0,
             32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        drain();
`ifdef WB_INSTRET_EN
        n_cmp++;
        if (instret !== 4'd1) begin
            n_err++;
            $display("FAIL instret_wrap: got %0d, required 1", instret);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
